// File: rtl/wf_route_unit.sv
// Registered West-First route unit for one mesh input port: computes the output port of
// each head flit, locks it per virtual channel, and replays it for body and tail flits.
module wf_route_unit #(
  parameter int MM  = 2,
  parameter int VCW = 2,
  parameter int CW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_valid,
  input  logic [VCW-1:0]        flit_vc,
  input  logic                  flit_head,
  input  logic                  flit_tail,
  input  logic [MM-1:0]         X,
  input  logic [MM-1:0]         Y,
  input  logic [MM-1:0]         x_final,
  input  logic [MM-1:0]         y_final,
  input  logic [CW-1:0]         credit_xp,
  input  logic [CW-1:0]         credit_yp,
  input  logic [CW-1:0]         credit_ym,
  output logic                  route_valid,
  output logic [VCW-1:0]        route_vc,
  output logic [4:0]            verification,
  output logic [(2**VCW)-1:0]   status,
  output logic                  err_flit
);

  localparam int VC = 2**VCW;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [4:0] PORT_XP = 5'b00001;
  localparam logic [4:0] PORT_XM = 5'b00010;
  localparam logic [4:0] PORT_YP = 5'b00100;
  localparam logic [4:0] PORT_YM = 5'b01000;
  localparam logic [4:0] PORT_EJ = 5'b10000;

  logic [VC-1:0]   state_q, state_d;
  logic [4:0]      dir_q [VC];
  logic [4:0]      dir_d [VC];
  logic            route_valid_q, route_valid_d;
  logic [VCW-1:0]  route_vc_q, route_vc_d;
  logic [4:0]      verification_q, verification_d;
  logic            err_flit_q, err_flit_d;

  logic [4:0]      route_calc;
  logic [4:0]      y_dir;
  logic [CW-1:0]   y_credit;

  // West hops are never adaptive; only an east-bound packet with a Y offset may choose.
  always_comb begin
    route_calc = '0;
    y_dir      = (y_final > Y) ? PORT_YP : PORT_YM;
    y_credit   = (y_final > Y) ? credit_yp : credit_ym;
    if (x_final == X && y_final == Y) begin
      route_calc = PORT_EJ;
    end else if (x_final < X) begin
      route_calc = PORT_XM;
    end else if (x_final > X) begin
      if (y_final == Y) begin
        route_calc = PORT_XP;
      end else begin
        route_calc = (y_credit > credit_xp) ? y_dir : PORT_XP;
      end
    end else begin
      route_calc = y_dir;
    end
  end

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    route_valid_d  = 1'b0;
    route_vc_d     = '0;
    verification_d = '0;
    err_flit_d     = 1'b0;
    if (flit_valid) begin
      route_vc_d = flit_vc;
      if (flit_head) begin
        if (state_q[flit_vc] == ST_IDLE) begin
          route_valid_d  = 1'b1;
          verification_d = route_calc;
          if (!flit_tail) begin
            state_d[flit_vc] = ST_ACTIVE;
            dir_d[flit_vc]   = route_calc;
          end
        end else begin
          err_flit_d = 1'b1;
        end
      end else if (state_q[flit_vc] == ST_ACTIVE) begin
        route_valid_d  = 1'b1;
        verification_d = dir_q[flit_vc];
        if (flit_tail) begin
          state_d[flit_vc] = ST_IDLE;
          dir_d[flit_vc]   = '0;
        end
      end else begin
        err_flit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= {VC{ST_IDLE}};
      for (int v = 0; v < VC; v++) dir_q[v] <= '0;
      route_valid_q  <= 1'b0;
      route_vc_q     <= '0;
      verification_q <= '0;
      err_flit_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      route_valid_q  <= route_valid_d;
      route_vc_q     <= route_vc_d;
      verification_q <= verification_d;
      err_flit_q     <= err_flit_d;
    end
  end

  assign route_valid  = route_valid_q;
  assign route_vc     = route_vc_q;
  assign verification = verification_q;
  assign status       = state_q;
  assign err_flit     = err_flit_q;

endmodule

// File: tb/tb_wf_route_unit.sv
// Self-checking bench for wf_route_unit: directed vector table, a hand-written lock
// sequence, and randomized traffic checked against a port-index reference model.
module tb_wf_route_unit;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [1:0] vc;
    logic       head;
    logic       tail;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] xf;
    logic [1:0] yf;
    logic [2:0] cxp;
    logic [2:0] cyp;
    logic [2:0] cym;
    logic       exp_valid;
    logic [1:0] exp_vc;
    logic [4:0] exp_verif;
    logic [3:0] exp_status;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flit_valid;
  logic [1:0] flit_vc;
  logic       flit_head;
  logic       flit_tail;
  logic [1:0] X, Y, x_final, y_final;
  logic [2:0] credit_xp, credit_yp, credit_ym;
  logic       route_valid;
  logic [1:0] route_vc;
  logic [4:0] verification;
  logic [3:0] status;
  logic       err_flit;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs[$];

  // Reference model state: lock flag and locked port index (0 X+,1 X-,2 Y+,3 Y-,4 Eject).
  bit ref_active [4];
  int ref_dir    [4];

  wf_route_unit #(.MM(2), .VCW(2), .CW(3)) dut (
    .clk(clk), .reset(reset), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .flit_head(flit_head), .flit_tail(flit_tail), .X(X), .Y(Y),
    .x_final(x_final), .y_final(y_final), .credit_xp(credit_xp),
    .credit_yp(credit_yp), .credit_ym(credit_ym), .route_valid(route_valid),
    .route_vc(route_vc), .verification(verification), .status(status),
    .err_flit(err_flit)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic valid, input logic [1:0] vc,
                              input logic head, input logic tail,
                              input logic [1:0] x, input logic [1:0] y,
                              input logic [1:0] xf, input logic [1:0] yf,
                              input logic [2:0] cxp, input logic [2:0] cyp, input logic [2:0] cym,
                              input logic exp_valid, input logic [1:0] exp_vc,
                              input logic [4:0] exp_verif, input logic [3:0] exp_status,
                              input logic exp_err);
    vec_t v;
    v.rst = rst; v.valid = valid; v.vc = vc; v.head = head; v.tail = tail;
    v.x = x; v.y = y; v.xf = xf; v.yf = yf; v.cxp = cxp; v.cyp = cyp; v.cym = cym;
    v.exp_valid = exp_valid; v.exp_vc = exp_vc; v.exp_verif = exp_verif;
    v.exp_status = exp_status; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic int ref_route(input int x, input int y, input int xf, input int yf,
                                   input int cxp, input int cyp, input int cym);
    int ycred;
    int yport;
    yport = (yf > y) ? 2 : 3;
    ycred = (yf > y) ? cyp : cym;
    if (xf == x && yf == y) return 4;
    if (xf < x) return 1;
    if (xf == x) return yport;
    if (yf == y) return 0;
    return (ycred > cxp) ? yport : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    reset      = v.rst;
    flit_valid = v.valid;
    flit_vc    = v.vc;
    flit_head  = v.head;
    flit_tail  = v.tail;
    X = v.x; Y = v.y; x_final = v.xf; y_final = v.yf;
    credit_xp = v.cxp; credit_yp = v.cyp; credit_ym = v.cym;
    @(posedge clk);
    #1;
    checkOutput({tag, " route_valid"},  32'(route_valid),  32'(v.exp_valid));
    checkOutput({tag, " verification"}, 32'(verification), 32'(v.exp_verif));
    checkOutput({tag, " err_flit"},     32'(err_flit),     32'(v.exp_err));
    checkOutput({tag, " status"},       32'(status),       32'(v.exp_status));
    if (v.exp_valid) checkOutput({tag, " route_vc"}, 32'(route_vc), 32'(v.exp_vc));
  endtask

  // Builds a random flit, predicts the outputs from the model, and advances the model.
  task automatic randomStep(input int idx);
    vec_t v;
    int   kind;
    int   p;
    v = '0;
    v.rst   = ($urandom_range(0, 49) == 0);
    v.valid = ($urandom_range(0, 9) < 8);
    v.vc    = 2'($urandom_range(0, 3));
    kind    = $urandom_range(0, 9);
    v.head  = (kind < 4);
    v.tail  = (kind == 0) || (kind >= 7);
    v.x  = 2'($urandom); v.y  = 2'($urandom);
    v.xf = 2'($urandom); v.yf = 2'($urandom);
    v.cxp = 3'($urandom); v.cyp = 3'($urandom); v.cym = 3'($urandom);
    if (v.rst) begin
      for (int i = 0; i < 4; i++) begin
        ref_active[i] = 1'b0;
        ref_dir[i]    = 0;
      end
    end else if (v.valid) begin
      if (v.head) begin
        if (ref_active[v.vc]) begin
          v.exp_err = 1'b1;
        end else begin
          p = ref_route(v.x, v.y, v.xf, v.yf, v.cxp, v.cyp, v.cym);
          v.exp_valid = 1'b1;
          v.exp_verif = 5'(1 << p);
          if (!v.tail) begin
            ref_active[v.vc] = 1'b1;
            ref_dir[v.vc]    = p;
          end
        end
      end else if (ref_active[v.vc]) begin
        v.exp_valid = 1'b1;
        v.exp_verif = 5'(1 << ref_dir[v.vc]);
        if (v.tail) ref_active[v.vc] = 1'b0;
      end else begin
        v.exp_err = 1'b1;
      end
      v.exp_vc = v.vc;
    end
    for (int i = 0; i < 4; i++) v.exp_status[i] = ref_active[i];
    applyStimulus(v, $sformatf("rnd[%0d]", idx));
  endtask

  initial begin
    reset = 1'b1; flit_valid = 1'b0; flit_vc = '0; flit_head = 1'b0; flit_tail = 1'b0;
    X = '0; Y = '0; x_final = '0; y_final = '0;
    credit_xp = '0; credit_yp = '0; credit_ym = '0;
    @(posedge clk);
    #1;

    //              rst val vc  hd tl  X  Y  xf yf cxp cyp cym  ev evc everif    estat    eerr
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0,   0, 0, 5'b00000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 0, 5'b10000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 2, 1, 0, 2, 1, 0, 3, 7, 0, 0,   1, 2, 5'b00010, 4'b0100, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 2, 1, 0, 3, 7, 0, 0,   1, 2, 5'b00010, 4'b0100, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 2, 1, 0, 3, 7, 0, 0,   1, 2, 5'b00010, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 1, 3, 3, 2, 5, 0,   1, 1, 5'b00100, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 3, 3, 5, 5, 0,   1, 1, 5'b00001, 4'b0010, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 3, 3, 0, 7, 0,   1, 1, 5'b00001, 4'b0010, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 1, 3, 3, 0, 7, 0,   1, 1, 5'b00001, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 2, 3, 2, 0, 0, 0,   1, 0, 5'b00001, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0,   1, 1, 5'b01000, 4'b0011, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0,   1, 0, 5'b00001, 4'b0011, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0,   1, 1, 5'b01000, 4'b0011, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0,   1, 0, 5'b00001, 4'b0011, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 4'b0011, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 4'b0011, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 4'b0011, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0,   1, 0, 5'b00001, 4'b0010, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 4'b0000, 1));
    vecs.push_back(mk(0, 1, 2, 1, 1, 1, 2, 3, 0, 1, 7, 3,   1, 2, 5'b01000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0,   1, 3, 5'b01000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 2, 3, 0, 0, 0,   1, 0, 5'b00001, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 2, 2, 3, 3, 0, 1, 0,   1, 1, 5'b00100, 4'b0000, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec[%0d]", i));

    // Lock vc3 westward, idle several cycles with wild credits, then close the packet.
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0), "seq rst");
    applyStimulus(mk(0, 1, 3, 1, 0, 2, 0, 1, 2, 7, 0, 0, 1, 3, 5'b00010, 4'b1000, 0), "seq head");
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(0, 0, 3, 0, 0, 2, 0, 3, 3, 0, 7, 7, 0, 0, 5'b00000, 4'b1000, 0),
                    $sformatf("seq idle%0d", i));
    applyStimulus(mk(0, 1, 3, 0, 1, 0, 3, 3, 3, 0, 7, 7, 1, 3, 5'b00010, 4'b0000, 0), "seq tail");

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0), "rnd rst");
    for (int i = 0; i < 4; i++) begin
      ref_active[i] = 1'b0;
      ref_dir[i]    = 0;
    end
    for (int i = 0; i < 500; i++) randomStep(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wf_route_unit.md
# wf_route_unit

Registered, per-virtual-channel West-First route computation unit for one input port of a 2-D mesh router. The unit computes an output port for each head flit using minimal West-First rules, with adaptive selection between X+ and the required Y direction driven by downstream credit counts. It locks that choice per virtual channel so body and tail flits follow the head. It sits between the input VC buffers and the switch allocator, and replaces the purely combinational route logic used in earlier router generations.

## Interface
- MM, default 2: coordinate width in bits per axis.
- VCW, default 2: virtual-channel index width; the number of VCs is VC = 2**VCW.
- CW, default 3: downstream credit-count width.

- clk  in  1  router clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- flit_valid  in  1  a flit descriptor is presented this cycle.
- flit_vc  in  VCW  VC of the presented flit.
- flit_head  in  1  flit is a head flit.
- flit_tail  in  1  flit is a tail flit; head and tail both high means a single-flit packet.
- X, Y  in  MM each  this router's coordinates.
- x_final, y_final  in  MM each  destination coordinates; sampled only when flit_head is high.
- credit_xp, credit_yp, credit_ym  in  CW each  free downstream slots on the X+, Y+ and Y− ports.
- route_valid  out  1  registered: verification/route_vc are valid.
- route_vc  out  VCW  registered VC of the routed flit.
- verification  out  5  registered one-hot port: bit0 X+ (Right), bit1 X− (Left), bit2 Y+ (Up), bit3 Y− (Down), bit4 Eject.
- status  out  VC  per-VC busy bit; 1 means the route is locked and the packet is in progress.
- err_flit  out  1  registered one-cycle protocol-error pulse.

## Operation
- Each VC has a two-state FSM (IDLE, ACTIVE) and a 5-bit stored direction, dir[v].
- **Head flit on an IDLE VC**: compute the route.
  - If x_final==X and y_final==Y, route to Eject.
  - If x_final<X, route to X− unconditionally (all west hops first; not adaptive).
  - If x_final>X and y_final==Y, route to X+.
  - If x_final>X and y_final≠Y, the candidates are X+ and Yd, where Yd is Y+ if y_final>Y and Y− otherwise.
    - Pick the candidate with the strictly larger credit.
    - On a tie (including both zero), pick X+.
  - If x_final==X, route to Y+ if y_final>Y and Y− if y_final<Y.
  - Comparisons are unsigned over MM bits. The credit compare is unsigned over CW bits.
  - The result goes to the output registers. It is also stored in dir[v] and the VC moves to ACTIVE, unless flit_tail is also high; a single-flit packet stays IDLE and dir is not stored.
- **Body flit on an ACTIVE VC**: output dir[v]. Credit changes never alter a locked route.
- **Tail flit on an ACTIVE VC**: output dir[v], then the VC goes to IDLE and dir[v] is cleared.
- **Body or tail flit on an IDLE VC**: route_valid=0 and err_flit=1 next cycle. State is unchanged.
- **Head flit on an ACTIVE VC**: route_valid=0 and err_flit=1. The flit is ignored, and dir[v] and the state are unchanged.
- status[v]=1 exactly when VC v is ACTIVE.
- Only one flit is accepted per cycle, so there are no simultaneous-VC conflicts.

## Timing
- Latency is 1 cycle: flit at edge n gives route_valid/route_vc/verification/err_flit valid after edge n+1. The outputs hold for one cycle only.
- flit_valid=0 in a cycle gives route_valid=0, verification=0 and err_flit=0 after the next edge.
- status updates on the same edge as the corresponding route output.
- Reset values: route_valid=0, route_vc=0, verification=0, status=0, err_flit=0, all VCs IDLE, all dir=0.
  - Reset has priority over a flit in the same cycle; that flit is discarded.
  - Reset mid-packet abandons all locks. Subsequent body flits on those VCs raise err_flit.
- verification is always one-hot when route_valid=1, and all-zero otherwise.

## Test plan
- **Eject, single-flit packet**: reset; X=1,Y=1, head+tail vc0 to (1,1) → next cycle route_valid=1, verification=5'b10000, route_vc=0, status=0.
- **West-first lock**: X=2,Y=1, head vc2 to (0,3) with credit_xp=7 → verification=5'b00010, status=4'b0100. Then body, then tail on vc2 → each gives 5'b00010; status=0 after the tail edge.
- **Adaptive choice**: X=1,Y=1, head to (3,3).
  - credit_xp=2, credit_yp=5 → 5'b00100.
  - credit_xp=5, credit_yp=5 (tie) → 5'b00001.
  - Change credits to xp=0, yp=7, then send a body flit → output stays 5'b00001.
- **Interleaved VCs**: X=1,Y=2.
  - Head vc0 to (3,2) → 5'b00001; head vc1 to (1,0) → 5'b01000.
  - Alternate body vc0/vc1 → 00001/01000 each time, with the matching route_vc; status=4'b0011.
- **Protocol errors**:
  - Body on idle vc3 → err_flit=1, route_valid=0.
  - Head on active vc0 → err_flit=1, dir[0] unchanged; the following vc0 tail still returns the original direction.
- **Reset mid-packet**: vc0 ACTIVE; assert reset with a simultaneous flit → all outputs 0, status=0. The next body flit on vc0 → err_flit=1.
